// File: rtl/p_s_tx.sv
`default_nettype none
// ============================================================================
// Module   : p_s_tx
// Purpose  : I2S parallel-to-serial transmitter for the codec DAC path.
//            Derives BCLK/LRCLK from MCLK, accepts a left/right sample pair
//            over valid/ready into a holding buffer, and shifts the active
//            pair out MSB-first, one BCLK after each LRCLK edge.
// Macro    : P_S_HOLD_LAST_EN - when defined, an underrun repeats the last
//            pair instead of sending zeros.
// Revision : 1.0 - initial release
// ============================================================================
module p_s_tx #(
  parameter int DATA_W         = 16,
  parameter int MCLK_PER_BCLK  = 4,
  parameter int BCLK_PER_FRAME = 64
) (
  input  logic              MCLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] LDATA_IN,
  input  logic [DATA_W-1:0] RDATA_IN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              BCLK_OUT,
  output logic              LRCLK_OUT,
  output logic              SDATA_OUT,
  output logic              BCLK_PULSE,
  output logic              FRAME_PULSE,
  output logic              UNDERRUN
);

  localparam int DIV_W = (MCLK_PER_BCLK > 1) ? $clog2(MCLK_PER_BCLK) : 1;
  localparam int BIT_W = $clog2(BCLK_PER_FRAME);
  localparam int HALF  = BCLK_PER_FRAME / 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_PER_BCLK - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BCLK_PER_FRAME - 1);
  localparam logic [BIT_W-1:0] L_FIRST  = BIT_W'(1);
  localparam logic [BIT_W-1:0] L_LAST   = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] R_HALF   = BIT_W'(HALF);
  localparam logic [BIT_W-1:0] R_FIRST  = BIT_W'(HALF + 1);
  localparam logic [BIT_W-1:0] R_LAST   = BIT_W'(HALF + DATA_W);

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_nxt;
  logic [BIT_W-1:0]  l_off;
  logic [BIT_W-1:0]  r_off;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] act_l;
  logic [DATA_W-1:0] act_r;
  logic              hold_full;
  logic              primed;
  logic              fe;
  logic              wrap;
  logic              accept;
  logic              sdata_nxt;

  // BCLK is the divider MSB: low for the first half of the period, high after
  assign BCLK_OUT  = div_cnt[DIV_W-1];
  assign DIN_READY = !hold_full;

  // Per-edge decode: BCLK falling edge, frame wrap, next bit index, handshake
  always_comb begin
    fe      = (div_cnt == DIV_LAST);
    wrap    = fe && (bit_cnt == BIT_LAST);
    bit_nxt = wrap ? '0 : bit_cnt + BIT_W'(1);
    accept  = DIN_VALID && !hold_full;
  end

  // Serial bit for the upcoming bit slot; MSB sits one slot after the LR edge
  always_comb begin
    l_off     = L_LAST - bit_nxt;
    r_off     = R_LAST - bit_nxt;
    sdata_nxt = 1'b0;
    if ((bit_nxt >= L_FIRST) && (bit_nxt <= L_LAST)) begin
      sdata_nxt = |(act_l & (DATA_W'(1) << l_off));
    end else if ((bit_nxt >= R_FIRST) && (bit_nxt <= R_LAST)) begin
      sdata_nxt = |(act_r & (DATA_W'(1) << r_off));
    end
  end

  // BCLK divider, bit counter, strobes; LRCLK/SDATA only move on BCLK fall
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      LRCLK_OUT   <= 1'b0;
      SDATA_OUT   <= 1'b0;
      BCLK_PULSE  <= 1'b0;
      FRAME_PULSE <= 1'b0;
    end else begin
      div_cnt     <= fe ? '0 : div_cnt + DIV_W'(1);
      BCLK_PULSE  <= fe;
      FRAME_PULSE <= wrap;
      if (fe) begin
        bit_cnt   <= bit_nxt;
        LRCLK_OUT <= (bit_nxt >= R_HALF);
        SDATA_OUT <= sdata_nxt;
      end
    end
  end

  // Holding buffer handshake and frame-boundary hand-over to the active pair.
  // The first wrap after reset closes a frame nobody could have fed, so it
  // never reports an underrun (primed marks that it has happened).
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
      act_l     <= '0;
      act_r     <= '0;
      primed    <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else begin
      UNDERRUN <= 1'b0;
      if (wrap) begin
        primed <= 1'b1;
        if (hold_full) begin
          act_l <= hold_l;
          act_r <= hold_r;
        end else begin
          UNDERRUN <= primed;
`ifdef P_S_HOLD_LAST_EN
          // active pair keeps its value: the last sample is repeated
`else
          act_l <= '0;
          act_r <= '0;
`endif
        end
      end
      // A pair offered on a wrap with hold empty is captured and plays next frame
      if (accept) begin
        hold_l    <= LDATA_IN;
        hold_r    <= RDATA_IN;
        hold_full <= 1'b1;
      end else if (wrap && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
